// File: rtl/hs32_xalu.sv
// Handshaked ALU with NZCV flags and multi-cycle unsigned MUL/DIVU/MODU; result registered.
// Latency 1 (logic/arith) or 1+WIDTH (mul/div); accepts only in IDLE, holds result until i_ready.
module hs32_xalu #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_fl,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_r,
    output logic [3:0]       o_fl
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_BIC  = 4'd6;
    localparam logic [3:0] OP_ADC  = 4'd7;
    localparam logic [3:0] OP_SBC  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_MODU = 4'd11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             cin_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             is_multi;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic             unused_fl;

    // N and Z inputs carry no information for any opcode.
    assign unused_fl = ^i_fl[3:2];

    assign o_ready  = (state == IDLE);
    assign accept   = i_valid & o_ready & ~i_flush;
    assign is_multi = (i_op == OP_MUL) || (i_op == OP_DIVU) || (i_op == OP_MODU);
    assign cin_ext  = {{WIDTH{1'b0}}, i_fl[1]};

    always_comb begin
        alu_sum = '0;
        alu_r   = i_b;
        alu_c   = i_fl[1];
        alu_v   = i_fl[0];
        case (i_op)
            OP_ADD, OP_ADC: begin
                alu_sum = {1'b0, i_a} + {1'b0, i_b} + ((i_op == OP_ADC) ? cin_ext : '0);
                alu_r   = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (alu_r[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the difference is the borrow.
                alu_sum = {1'b0, i_a} - {1'b0, i_b} - ((i_op == OP_SBC) ? cin_ext : '0);
                alu_r   = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (alu_r[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  alu_r = i_a & i_b;
            OP_OR:   alu_r = i_a | i_b;
            OP_XOR:  alu_r = i_a ^ i_b;
            OP_BIC:  alu_r = i_a & ~i_b;
            default: alu_r = i_b;
        endcase
    end

    // One shift-add step: {hi,lo} holds partial product, multiplier drains out of lo.
    logic [WIDTH:0]   mul_t;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    // One restoring-divide step: hi is the remainder, lo shifts dividend out and quotient in.
    logic [WIDTH:0]   div_r2;
    logic             div_ge;
    logic [WIDTH-1:0] div_d;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] fin_r;
    logic             fin_v;

    always_comb begin
        mul_t  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
        mul_hi = mul_t[WIDTH:1];
        mul_lo = {mul_t[0], lo[WIDTH-1:1]};
        div_r2 = {hi, lo[WIDTH-1]};
        div_ge = (div_r2 >= {1'b0, b_q});
        div_d  = div_r2[WIDTH-1:0] - b_q;
        div_hi = div_ge ? div_d : div_r2[WIDTH-1:0];
        div_lo = {lo[WIDTH-2:0], div_ge};
        nxt_hi = (op_q == OP_MUL) ? mul_hi : div_hi;
        nxt_lo = (op_q == OP_MUL) ? mul_lo : div_lo;
        fin_r  = (op_q == OP_MODU) ? nxt_hi : nxt_lo;
        fin_v  = (op_q == OP_MUL) ? (|nxt_hi) : (b_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_r     <= '0;
            o_fl    <= '0;
        end else if (i_flush) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= i_a;
                        b_q   <= i_b;
                        op_q  <= i_op;
                        cin_q <= i_fl[1];
                        if (is_multi) begin
                            state <= BUSY;
                            cnt   <= CNT_W'(WIDTH);
                            hi    <= '0;
                            lo    <= (i_op == OP_MUL) ? i_b : i_a;
                        end else begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_r     <= alu_r;
                            o_fl    <= {alu_r[WIDTH-1], ~|alu_r, alu_c, alu_v};
                        end
                    end
                end
                BUSY: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_r     <= fin_r;
                        o_fl    <= {fin_r[WIDTH-1], ~|fin_r, cin_q, fin_v};
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_xalu.sv
// Scoreboard bench for hs32_xalu: driver pushes hand-computed results, monitor pops on handshake.
module tb_hs32_xalu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_flush, i_valid, i_ready;
    logic [3:0]   i_op, i_fl;
    logic [W-1:0] i_a, i_b;
    logic         o_ready, o_valid;
    logic [W-1:0] o_r;
    logic [3:0]   o_fl;

    logic         w8_valid, w8_o_ready, w8_o_valid;
    logic [7:0]   w8_a, w8_b, w8_r;
    logic [3:0]   w8_op, w8_o_fl;

    always #5 clk = ~clk;

    hs32_xalu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_fl(i_fl), .o_valid(o_valid), .i_ready(i_ready),
        .o_r(o_r), .o_fl(o_fl)
    );

    hs32_xalu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .i_flush(1'b0), .i_valid(w8_valid), .o_ready(w8_o_ready),
        .i_op(w8_op), .i_a(w8_a), .i_b(w8_b), .i_fl(4'h0), .o_valid(w8_o_valid), .i_ready(1'b1),
        .o_r(w8_r), .o_fl(w8_o_fl)
    );

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  fl;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && o_valid && i_ready) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected result: got r=%0h fl=%0h with nothing outstanding", o_r, o_fl);
            end else begin
                mon_e = sbq.pop_front();
                check("result r", 64'(o_r), 64'(mon_e.r));
                check("result fl", 64'(o_fl), 64'(mon_e.fl));
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!o_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!o_ready) check("o_ready timeout", 64'(o_ready), 64'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] fl, input logic [31:0] er, input logic [3:0] efl,
                         input int elat, input int hold);
        int lat;
        bit rdy_seen;
        wait_ready();
        i_op = op; i_a = a; i_b = b; i_fl = fl;
        i_valid = 1'b1;
        i_ready = (hold == 0);
        sbq.push_back('{er, efl});
        @(posedge clk); #1;
        // Scramble inputs after accept: the result must depend only on sampled values.
        i_valid = 1'b0;
        i_a = $urandom; i_b = $urandom; i_fl = 4'hF; i_op = 4'd1;
        lat = 1;
        rdy_seen = 1'b0;
        while (!o_valid && lat < 200) begin
            if (o_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(elat));
        if (elat > 1) check("o_ready low in BUSY", 64'(rdy_seen), 64'd0);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
            end
            check("held o_valid", 64'(o_valid), 64'd1);
            check("held o_r", 64'(o_r), 64'(er));
            check("held o_ready", 64'(o_ready), 64'd0);
            i_ready = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit seen;
        reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op = '0; i_a = '0; i_b = '0; i_fl = '0;
        w8_valid = 1'b0; w8_op = '0; w8_a = '0; w8_b = '0;
        #2;
        check("reset o_valid", 64'(o_valid), 64'd0);
        check("reset o_r", 64'(o_r), 64'd0);
        check("reset o_fl", 64'(o_fl), 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("o_ready after reset", 64'(o_ready), 64'd1);

        issue(4'd1, 32'h7FFFFFFF, 32'h1,        4'b0000, 32'h80000000, 4'b1001, 1, 0);
        issue(4'd2, 32'h0,        32'h1,        4'b0000, 32'hFFFFFFFF, 4'b1010, 1, 0);
        issue(4'd7, 32'hFFFFFFFF, 32'h0,        4'b0010, 32'h0,        4'b0110, 1, 5);
        issue(4'd8, 32'h5,        32'h3,        4'b0010, 32'h1,        4'b0000, 1, 0);
        issue(4'd2, 32'h80000000, 32'h1,        4'b0000, 32'h7FFFFFFF, 4'b0001, 1, 0);
        issue(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011, 32'h00F000F0, 4'b0011, 1, 0);
        issue(4'd4, 32'h0,        32'h0,        4'b0000, 32'h0,        4'b0100, 1, 0);
        issue(4'd5, 32'hFFFF0000, 32'h0000FFFF, 4'b0000, 32'hFFFFFFFF, 4'b1000, 1, 0);
        issue(4'd6, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000, 32'hFFFF0000, 4'b1000, 1, 0);
        issue(4'd0, 32'hDEADBEEF, 32'h12345678, 4'b0000, 32'h12345678, 4'b0000, 1, 0);
        issue(4'd15, 32'h1,       32'h0,        4'b0001, 32'h0,        4'b0101, 1, 0);
        issue(4'd9, 32'h00010000, 32'h00010000, 4'b0000, 32'h0,        4'b0101, 33, 0);
        issue(4'd9, 32'h00012345, 32'h100,      4'b0010, 32'h01234500, 4'b0010, 33, 0);
        issue(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 32'h1,        4'b0001, 33, 0);
        issue(4'd10, 32'h100,     32'h7,        4'b0000, 32'h24,       4'b0000, 33, 0);
        issue(4'd11, 32'h100,     32'h7,        4'b0000, 32'h4,        4'b0000, 33, 0);
        issue(4'd10, 32'h5,       32'h0,        4'b0000, 32'hFFFFFFFF, 4'b1001, 33, 0);
        issue(4'd11, 32'h5,       32'h0,        4'b0000, 32'h5,        4'b0001, 33, 0);
        issue(4'd10, 32'hFFFFFFFF, 32'h10,      4'b0010, 32'h0FFFFFFF, 4'b0010, 33, 0);

        // Flush a divide mid-flight, then a request presented together with flush.
        wait_ready();
        i_op = 4'd10; i_a = 32'h100; i_b = 32'h7; i_fl = 4'h0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            if (o_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush o_ready", 64'(o_ready), 64'd1);
        check("flush o_valid", 64'(o_valid), 64'd0);
        i_op = 4'd1; i_a = 32'h1; i_b = 32'h1; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush blocks accept", 64'(o_ready), 64'd1);
        repeat (40) begin
            if (o_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("no result after flush", 64'(seen), 64'd0);
        issue(4'd1, 32'h1, 32'h2, 4'b0000, 32'h3, 4'b0000, 1, 0);

        // Reset asserted five cycles into a multiply.
        wait_ready();
        i_op = 4'd9; i_a = 32'h3; i_b = 32'h5; i_fl = 4'h0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        check("mid-BUSY reset o_valid", 64'(o_valid), 64'd0);
        check("mid-BUSY reset o_r", 64'(o_r), 64'd0);
        check("mid-BUSY reset o_fl", 64'(o_fl), 64'd0);
        @(negedge clk) reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        check("no result after reset", 64'(seen), 64'd0);
        check("o_ready after abort", 64'(o_ready), 64'd1);

        // WIDTH=8 instance: 0x10*0x10 overflows into the high half.
        w8_op = 4'd9; w8_a = 8'h10; w8_b = 8'h10; w8_valid = 1'b1;
        @(posedge clk); #1;
        w8_valid = 1'b0;
        guard = 1;
        while (!w8_o_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("w8 latency", 64'(guard), 64'd9);
        check("w8 o_r", 64'(w8_r), 64'h00);
        check("w8 o_fl", 64'(w8_o_fl), 64'b0101);

        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard drained", 64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
